// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: multi-precision front end driving a 4-bit ALU one nibble per pass with carry/borrow/shift fixups
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready high only when idle
//   cmd_op                3-bit op, ALU select encoding (ADD SUB AND OR XOR SHL SHR NOT)
//   cmd_a, cmd_b          4*NIBBLES-bit operands (cmd_b unused for SHL/SHR/NOT)
//   alu_a, alu_b, alu_sel registered drive to the external 4-bit ALU
//   alu_out, alu_carry    ALU result and carry/borrow, sampled at the next edge
//   rsp_valid/rsp_ready   response handshake
//   rsp_result, rsp_carry full result; carry, borrow or shifted-out bit
//   rsp_zero              only when ALU_SEQ_ZERO_FLAG_EN is defined: result == 0
module alu_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [4*NIBBLES-1:0] cmd_a,
   input  logic [4*NIBBLES-1:0] cmd_b,
   output logic [3:0]           alu_a,
   output logic [3:0]           alu_b,
   output logic [2:0]           alu_sel,
   input  logic [3:0]           alu_out,
   input  logic                 alu_carry,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [4*NIBBLES-1:0] rsp_result,
   output logic                 rsp_carry
`ifdef ALU_SEQ_ZERO_FLAG_EN
   ,
   output logic                 rsp_zero
`endif
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES);
   typedef enum logic [1:0] {IDLE, EXEC, FIX, DONE} state_t;
   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]    op_q, op_d, alu_sel_q, alu_sel_d;
   logic [3:0]    alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [CW-1:0] cnt_q, cnt_d, idx, nidx;
   logic          p_q, p_d, pn_q, pn_d, carry_q, carry_d;
   logic          addsub, shl, shr, last, pn, adv;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic          zero_q, zero_d;
   assign rsp_zero = zero_q;
`endif
   assign addsub = op_q[2:1] == 2'b00;
   assign shl    = op_q == 3'd5;
   assign shr    = op_q == 3'd6;
   // SHR walks nibbles high-to-low so the shifted bit flows downward
   assign idx    = shr ? CW'(NIBBLES - 1) - cnt_q : cnt_q;
   assign nidx   = shr ? idx - CW'(1) : idx + CW'(1);
   assign last   = cnt_q == CW'(NIBBLES - 1);
   // bit handed to the next nibble: ALU carry/borrow, or the bit shifted out of the original nibble
   assign pn     = addsub ? alu_carry : shl ? a_q[idx*4+3] : (shr & a_q[idx*4]);
   assign cmd_ready  = state_q == IDLE;
   assign rsp_valid  = state_q == DONE;
   assign rsp_result = res_q;
   assign rsp_carry  = carry_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_sel    = alu_sel_q;
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      op_d      = op_q;
      res_d     = res_q;
      cnt_d     = cnt_q;
      p_d       = p_q;
      pn_d      = pn_q;
      carry_d   = carry_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_sel_d = alu_sel_q;
      adv       = 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
      zero_d    = zero_q;
`endif
      case (state_q)
         IDLE: if (cmd_valid) begin
            state_d   = EXEC;
            a_d       = cmd_a;
            b_d       = cmd_b;
            op_d      = cmd_op;
            cnt_d     = '0;
            p_d       = 1'b0;
            alu_a_d   = cmd_op == 3'd6 ? cmd_a[W-1 -: 4] : cmd_a[3:0];
            alu_b_d   = cmd_op <= 3'd4 ? cmd_b[3:0] : 4'h0;
            alu_sel_d = cmd_op;
         end
         EXEC: begin
            res_d[idx*4 +: 4] = alu_out;
            if (p_q && (addsub || shl || shr)) begin
               // inject the incoming bit: +/-1 for arithmetic, OR into the vacated bit for shifts
               state_d   = FIX;
               pn_d      = pn;
               alu_a_d   = alu_out;
               alu_b_d   = shr ? 4'h8 : 4'h1;
               alu_sel_d = addsub ? op_q : 3'b011;
            end else begin
               p_d = pn;
               adv = 1'b1;
            end
         end
         FIX: begin
            res_d[idx*4 +: 4] = alu_out;
            p_d = pn_q | (addsub & alu_carry);
            adv = 1'b1;
         end
         DONE: if (rsp_ready) state_d = IDLE;
      endcase
      if (adv) begin
         if (last) begin
            state_d = DONE;
            carry_d = p_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            zero_d  = res_d == '0;
`endif
         end else begin
            state_d   = EXEC;
            cnt_d     = cnt_q + CW'(1);
            alu_a_d   = a_q[nidx*4 +: 4];
            alu_b_d   = op_q <= 3'd4 ? b_q[nidx*4 +: 4] : 4'h0;
            alu_sel_d = op_q;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         res_q     <= '0;
         cnt_q     <= '0;
         p_q       <= 1'b0;
         pn_q      <= 1'b0;
         carry_q   <= 1'b0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_sel_q <= '0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         zero_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         op_q      <= op_d;
         res_q     <= res_d;
         cnt_q     <= cnt_d;
         p_q       <= p_d;
         pn_q      <= pn_d;
         carry_q   <= carry_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_sel_q <= alu_sel_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         zero_q    <= zero_d;
`endif
      end
   end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// tb_alu_nibble_sequencer: directed and randomized bench with a behavioural ALU and word-level reference model
module tb_alu_nibble_sequencer;
   localparam int N = 4;
   localparam int W = 4 * N;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [2:0]   cmd_op = '0;
   logic [W-1:0] cmd_a = '0;
   logic [W-1:0] cmd_b = '0;
   logic [3:0]   alu_a, alu_b, alu_out;
   logic [2:0]   alu_sel;
   logic         alu_carry;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [W-1:0] rsp_result;
   logic         rsp_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic         rsp_zero;
`endif
   int checks = 0;
   int errors = 0;

   alu_nibble_sequencer #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry)
`ifdef ALU_SEQ_ZERO_FLAG_EN
      , .rsp_zero(rsp_zero)
`endif
   );

   always #5 clk = ~clk;

   // behavioural 4-bit ALU
   always_comb begin
      alu_out   = 4'h0;
      alu_carry = 1'b0;
      case (alu_sel)
         3'd0: {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
         3'd1: {alu_carry, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
         3'd2: alu_out = alu_a & alu_b;
         3'd3: alu_out = alu_a | alu_b;
         3'd4: alu_out = alu_a ^ alu_b;
         3'd5: {alu_carry, alu_out} = {alu_a, 1'b0};
         3'd6: {alu_out, alu_carry} = {1'b0, alu_a};
         default: alu_out = ~alu_a;
      endcase
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // word-level result: {carry, result}
   function automatic logic [W:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      logic [63:0] a64, b64, s;
      a64 = 64'(a);
      b64 = 64'(b);
      s   = 64'd0;
      case (op)
         3'd0: s = a64 + b64;
         3'd1: s = ((a64 - b64) & ((64'd1 << W) - 1)) | (a64 < b64 ? (64'd1 << W) : 64'd0);
         3'd2: s = a64 & b64;
         3'd3: s = a64 | b64;
         3'd4: s = a64 ^ b64;
         3'd5: s = a64 << 1;
         3'd6: s = (a64 >> 1) | (a64[0] ? (64'd1 << W) : 64'd0);
         default: s = ~a64 & ((64'd1 << W) - 1);
      endcase
      return s[W:0];
   endfunction

   // passes = nibbles + one fixup per nibble whose incoming carry/borrow/shift bit is 1
   function automatic int ref_lat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      logic [63:0] m, a64, b64;
      n   = N;
      a64 = 64'(a);
      b64 = 64'(b);
      for (int i = 1; i < N; i++) begin
         m = (64'd1 << (4 * i)) - 1;
         if (op == 3'd0 && (((a64 & m) + (b64 & m)) >> (4 * i)) != 0) n++;
         if (op == 3'd1 && (a64 & m) < (b64 & m)) n++;
         if (op == 3'd5 && a[4*i-1]) n++;
         if (op == 3'd6 && a[4*i]) n++;
      end
      return n;
   endfunction

   // starts and ends at a negedge; ends at the negedge after the accepting edge
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int k;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_valid = 1'b1;
      k = 0;
      while (!cmd_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("cmd_ready_before_accept", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      cmd_op    = 3'($urandom);
      cmd_a     = W'($urandom);
      cmd_b     = W'($urandom);
   endtask

   task automatic wait_rsp(input string tag, input logic [W-1:0] er, input logic ec, input int elat);
      int lat;
      lat = 0;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'(elat));
      chk({tag, "_result"}, 64'(rsp_result), 64'(er));
      chk({tag, "_carry"}, 64'(rsp_carry), 64'(ec));
`ifdef ALU_SEQ_ZERO_FLAG_EN
      chk({tag, "_zero"}, 64'(rsp_zero), 64'(er == '0));
`endif
   endtask

   task automatic release_rsp(input string tag, input int hold, input logic [W-1:0] er, input logic ec);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
         chk({tag, "_hold_result"}, 64'({rsp_carry, rsp_result}), 64'({ec, er}));
         chk({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, "_cmd_ready_after"}, 64'(cmd_ready), 64'd1);
      chk({tag, "_valid_after"}, 64'(rsp_valid), 64'd0);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] er, input logic ec, input int elat);
      issue(op, a, b);
      wait_rsp(tag, er, ec, elat);
      release_rsp(tag, 0, er, ec);
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      logic [W:0]   r;
      @(negedge clk);
      @(negedge clk);
      chk("reset_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("reset_outputs", 64'({rsp_valid, rsp_carry, rsp_result, alu_a, alu_b, alu_sel}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      run("add", 3'd0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 6);
      run("sub", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 7);
      run("and", 3'd2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 4);
      run("shl", 3'd5, 16'h8888, 16'h0000, 16'h1110, 1'b1, 7);
      run("shr", 3'd6, 16'h0001, 16'hFFFF, 16'h0000, 1'b1, 4);
      run("not", 3'd7, 16'h1234, 16'hFFFF, 16'hEDCB, 1'b0, 4);
      run("sub_eq", 3'd1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 4);
      run("or", 3'd3, 16'h0000, 16'h0001, 16'h0001, 1'b0, 4);
      run("add_wrap", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 7);
      run("shr_mid", 3'd6, 16'h1111, 16'h0000, 16'h0888, 1'b1, 7);
      // backpressure with a second command waiting
      issue(3'd4, 16'h0F0F, 16'h00FF);
      wait_rsp("bp", 16'h0FF0, 1'b0, 4);
      cmd_op    = 3'd0;
      cmd_a     = 16'h0F0F;
      cmd_b     = 16'h0101;
      cmd_valid = 1'b1;
      release_rsp("bp", 10, 16'h0FF0, 1'b0);
      issue(3'd0, 16'h0F0F, 16'h0101);
      wait_rsp("bp_second", 16'h1010, 1'b0, 6);
      release_rsp("bp_second", 1, 16'h1010, 1'b0);
      // asynchronous reset during the third pass of an ADD
      issue(3'd0, 16'h1234, 16'h1111);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("pre_reset_busy", 64'(cmd_ready), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("async_reset_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("async_reset_outputs", 64'({rsp_valid, rsp_carry, rsp_result, alu_a, alu_b, alu_sel}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run("xor_after_reset", 3'd4, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 4);
      // randomized commands against the word-level model
      for (int i = 0; i < 40; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = W'($urandom);
         b  = (i % 5 == 0) ? a : W'($urandom);
         if (i % 7 == 0) a = '1;
         r  = ref_res(op, a, b);
         issue(op, a, b);
         wait_rsp("rand", r[W-1:0], r[W], ref_lat(op, a, b));
         release_rsp("rand", $urandom_range(0, 2), r[W-1:0], r[W]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
